fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch. Owns the PC register, selects the next PC (reset vector,
//  redirect, sequential +PC_STEP), and issues one-outstanding fetch requests to imem via
//  req/gnt/rvalid. Delivers fetched instruction plus its PC to decode, honouring decode stall.
// PARAMETERS
//  ADDR_W        32            PC / imem address width
//  RESET_VECTOR  32'h0000_0000 PC loaded on reset
//  PC_STEP       4             sequential PC increment (bytes)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous, active-low reset
//  redirect_valid  in   1       branch/jump taken this cycle (from execute)
//  redirect_pc     in   ADDR_W  redirect target
//  stall           in   1       decode cannot accept instr this cycle
//  imem_req        out  1       fetch request
//  imem_addr       out  ADDR_W  fetch address (= current PC)
//  imem_gnt        in   1       imem accepted request
//  imem_rvalid     in   1       imem_rdata valid
//  imem_rdata      in   32      fetched word
//  instr_valid     out  1       instr/instr_pc valid to decode
//  instr           out  32      fetched instruction
//  instr_pc        out  ADDR_W  PC of instr
//  pc_result       out  ADDR_W  current PC register
//  misalign_err    out  1       only with FETCH_MISALIGN_TRAP_EN, else tied 0
// BEHAVIOUR
//  Reset (rst=0, async): pc_result=RESET_VECTOR, state=IDLE, imem_req=0, imem_addr=RESET_VECTOR,
//   instr_valid=0, instr=0, instr_pc=0, misalign_err=0, kill=0. All outputs registered.
//  FSM: IDLE -> REQ (unconditional, 1 cycle after reset release; first imem_req in cycle 2).
//   REQ : imem_req=1, imem_addr=pc. gnt=1 -> WAIT. Addr stable until gnt unless redirect.
//   WAIT: imem_req=0. On rvalid: if kill, drop data, kill<=0, -> REQ (at pc);
//         else instr<=rdata, instr_pc<=pc, instr_valid<=1 next cycle, pc<=pc+PC_STEP;
//         stall=0 -> REQ, stall=1 -> HOLD.
//   HOLD: instr_valid/instr/instr_pc frozen while stall=1; stall=0 -> REQ (consumed that cycle).
//  instr_valid: single-cycle per word unless held by stall; cleared on the cycle decode takes it.
//  Max throughput: one instr per 2 cycles at gnt/rvalid each 1-cycle.
//  Redirect (highest priority, any state except IDLE): pc<=redirect_pc next cycle;
//   REQ before gnt -> stay REQ, imem_addr updates next cycle; REQ with gnt same cycle -> WAIT,kill=1;
//   WAIT -> stay WAIT, kill=1 (in-flight response discarded); HOLD -> instr_valid<=0, -> REQ.
//   Redirect with rvalid in same cycle: data discarded, no instr_valid.
//   Redirect + stall together: redirect wins; pending instr dropped.
//  Arithmetic: pc+PC_STEP modulo 2^ADDR_W (wraps 0xFFFF_FFFC -> 0x0000_0000 silently).
//  Only one outstanding request; gnt ignored outside REQ, rvalid ignored outside WAIT.
//  Reset asserted mid-transaction: all state cleared immediately; late rvalid after reset ignored.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 -> redirect not taken, pc unchanged,
//   misalign_err pulses 1 cycle after redirect, fetch continues sequentially.
//  Undefined: redirect_pc used as-is (low bits passed to imem_addr); misalign_err tied 0.
// STRUCTURE
//  fetch_pkg: state enum {IDLE,REQ,WAIT,HOLD}, default RESET_VECTOR, PC_STEP constants.
//  One sub-module: pc_next_sel (combinational next-PC priority mux: reset/redirect/inc/hold).
//  FSM, kill flag and output registers live in fetch_sequencer.
// TESTING
//  1 Reset release, gnt/rvalid 1-cycle -> imem_addr 0x0,0x4,0x8; instr_pc matches; instr=rdata.
//  2 stall=1 for 5 cycles after rvalid -> instr_valid held, instr stable, no imem_req until stall=0.
//  3 redirect 0x100 in WAIT, then rvalid -> data dropped, next imem_addr=0x100, no instr_valid.
//  4 redirect 0x200 while in REQ with gnt=0 -> imem_addr 0x200 next cycle, req stays high.
//  5 pc=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000.
//  6 EN: redirect 0x102 -> misalign_err pulse, next addr=pc+4; unset: next addr=0x102.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam int          DEFAULT_ADDR_W       = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_PC_STEP      = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/grant/response bus between the fetch sequencer and imem.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: reset vector, then redirect target, then sequential step, else hold.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter int                PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              load_reset,
  input  logic              redirect_taken,
  input  logic              advance,
  output logic [ADDR_W-1:0] next_pc
);

  // The sequential step wraps modulo 2^ADDR_W.
  always_comb begin
    next_pc = cur_pc;
    if (load_reset) begin
      next_pc = RESET_VECTOR;
    end else if (redirect_taken) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = cur_pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one-outstanding imem requests, feeds decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN rejects misaligned redirects and pulses misalign_err.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter int                PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  fetch_if.master           imem,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_result,
  output logic              misalign_err
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              kill;
  logic              redirect_ok;
  logic              redirect_taken;
  logic              load_reset;
  logic              advance;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned  = redirect_pc[1:0] != 2'b00;
  assign redirect_ok = redirect_valid && !misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && misaligned && (state != IDLE);
    end
  end
`else
  assign redirect_ok  = redirect_valid;
  assign misalign_err = 1'b0;
`endif

  assign redirect_taken = redirect_ok && (state != IDLE);
  assign load_reset     = state == IDLE;
  assign advance        = (state == WAIT) && imem.imem_rvalid && !kill && !redirect_taken;

  assign imem.imem_addr = pc;
  assign pc_result      = pc;

  pc_next_sel #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RESET_VECTOR),
    .PC_STEP     (PC_STEP)
  ) u_pc_next_sel (
    .cur_pc        (pc),
    .redirect_pc   (redirect_pc),
    .load_reset    (load_reset),
    .redirect_taken(redirect_taken),
    .advance       (advance),
    .next_pc       (next_pc)
  );

  // A redirect that lands while a response is in flight sets kill so that response is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc             <= RESET_VECTOR;
      imem.imem_req  <= 1'b0;
      kill           <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
    end else begin
      pc          <= next_pc;
      instr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          state         <= REQ;
          imem.imem_req <= 1'b1;
        end
        REQ: begin
          if (imem.imem_gnt) begin
            state         <= WAIT;
            imem.imem_req <= 1'b0;
            kill          <= redirect_taken;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            kill <= 1'b0;
            if (redirect_taken || kill) begin
              state         <= REQ;
              imem.imem_req <= 1'b1;
            end else begin
              instr       <= imem.imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              if (stall) begin
                state <= HOLD;
              end else begin
                state         <= REQ;
                imem.imem_req <= 1'b1;
              end
            end
          end else if (redirect_taken) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_taken || !stall) begin
            state         <= REQ;
            imem.imem_req <= 1'b1;
          end else begin
            instr_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; expectations follow FETCH_MISALIGN_TRAP_EN when defined.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_result;
  logic        misalign_err;
  int          check_count;
  int          error_count;

  fetch_if #(.ADDR_W(32)) bus ();

  fetch_sequencer #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'h0000_0000),
    .PC_STEP     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem          (bus),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_result     (pc_result),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then settle before sampling.
  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic stl, input logic rdr, input logic [31:0] rdr_pc);
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rvalid;
    bus.imem_rdata  = rdata;
    stall           = stl;
    redirect_valid  = rdr;
    redirect_pc     = rdr_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkDelivery(input string tag, input logic [31:0] data, input logic [31:0] pc,
                               input logic [31:0] next_addr);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_instr"}, instr, data);
    checkOutput({tag, "_pc"}, instr_pc, pc);
    checkOutput({tag, "_addr"}, bus.imem_addr, next_addr);
  endtask

  initial begin
    logic [31:0] exp_pc6;
    check_count     = 0;
    error_count     = 0;
    rst             = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_pc", pc_result, 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);

    // Sequential fetch with single-cycle gnt and rvalid
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_req_first", 32'(bus.imem_req), 32'd1);
    checkOutput("t1_addr0", bus.imem_addr, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t1_wait_req", 32'(bus.imem_req), 32'd0);
    applyStimulus(0, 1, 32'hA000_0000, 0, 0, 0);
    checkDelivery("t1_w0", 32'hA000_0000, 32'h0, 32'h4);
    checkOutput("t1_req_again", 32'(bus.imem_req), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t1_valid_pulse", 32'(instr_valid), 32'd0);
    applyStimulus(0, 1, 32'hA000_0001, 0, 0, 0);
    checkDelivery("t1_w1", 32'hA000_0001, 32'h4, 32'h8);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hA000_0002, 0, 0, 0);
    checkDelivery("t1_w2", 32'hA000_0002, 32'h8, 32'hC);

    // Decode stall holds the delivered word and blocks new requests
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hB000_0000, 1, 0, 0);
    checkDelivery("t2_hold", 32'hB000_0000, 32'hC, 32'h10);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t2_held_valid", 32'(instr_valid), 32'd1);
      checkOutput("t2_held_instr", instr, 32'hB000_0000);
      checkOutput("t2_held_noreq", 32'(bus.imem_req), 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_release_valid", 32'(instr_valid), 32'd0);
    checkOutput("t2_release_req", 32'(bus.imem_req), 32'd1);
    checkOutput("t2_release_addr", bus.imem_addr, 32'h10);

    // Redirect while waiting: in-flight response is dropped
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h100);
    checkOutput("t3_wait_req", 32'(bus.imem_req), 32'd0);
    checkOutput("t3_wait_addr", bus.imem_addr, 32'h100);
    applyStimulus(0, 1, 32'hDEAD_0003, 0, 0, 0);
    checkOutput("t3_drop_valid", 32'(instr_valid), 32'd0);
    checkOutput("t3_drop_req", 32'(bus.imem_req), 32'd1);
    checkOutput("t3_drop_addr", bus.imem_addr, 32'h100);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hC000_0000, 0, 0, 0);
    checkDelivery("t3_target", 32'hC000_0000, 32'h100, 32'h104);

    // Redirect in REQ before grant, then redirect together with grant
    applyStimulus(0, 0, 0, 0, 1, 32'h200);
    checkOutput("t4_req", 32'(bus.imem_req), 32'd1);
    checkOutput("t4_addr", bus.imem_addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_addr_stable", bus.imem_addr, 32'h200);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hD000_0000, 0, 0, 0);
    checkDelivery("t4_target", 32'hD000_0000, 32'h200, 32'h204);
    applyStimulus(1, 0, 0, 0, 1, 32'h300);
    checkOutput("t4g_req", 32'(bus.imem_req), 32'd0);
    checkOutput("t4g_addr", bus.imem_addr, 32'h300);
    applyStimulus(0, 1, 32'hDEAD_0004, 0, 0, 0);
    checkOutput("t4g_drop_valid", 32'(instr_valid), 32'd0);
    checkOutput("t4g_drop_addr", bus.imem_addr, 32'h300);

    // Redirect plus stall while holding: redirect wins, held word dropped
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hE000_0000, 1, 0, 0);
    checkDelivery("th_hold", 32'hE000_0000, 32'h300, 32'h304);
    applyStimulus(0, 0, 0, 1, 1, 32'h400);
    checkOutput("th_valid", 32'(instr_valid), 32'd0);
    checkOutput("th_req", 32'(bus.imem_req), 32'd1);
    checkOutput("th_addr", bus.imem_addr, 32'h400);

    // PC wraps at the top of the address space
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    checkOutput("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hF000_0000, 0, 0, 0);
    checkDelivery("t5_wrap", 32'hF000_0000, 32'hFFFF_FFFC, 32'h0);

    // Misaligned redirect target
    applyStimulus(0, 0, 0, 0, 1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_pc6 = 32'h0;
    checkOutput("t6_misalign_pulse", 32'(misalign_err), 32'd1);
`else
    exp_pc6 = 32'h102;
    checkOutput("t6_misalign_pulse", 32'(misalign_err), 32'd0);
`endif
    checkOutput("t6_addr", bus.imem_addr, exp_pc6);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t6_misalign_clear", 32'(misalign_err), 32'd0);
    applyStimulus(0, 1, 32'h6000_0000, 0, 0, 0);
    checkDelivery("t6_next", 32'h6000_0000, exp_pc6, exp_pc6 + 32'd4);

    // Asynchronous reset mid-transaction; late rvalid must be ignored
    applyStimulus(1, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("tr_req", 32'(bus.imem_req), 32'd0);
    checkOutput("tr_addr", bus.imem_addr, 32'h0);
    checkOutput("tr_instr_pc", instr_pc, 32'h0);
    applyStimulus(0, 1, 32'hDEAD_0005, 0, 0, 0);
    checkOutput("tr_held_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    applyStimulus(0, 1, 32'hDEAD_0006, 0, 0, 0);
    checkOutput("tr_idle_valid", 32'(instr_valid), 32'd0);
    checkOutput("tr_idle_req", 32'(bus.imem_req), 32'd1);
    applyStimulus(0, 1, 32'hDEAD_0007, 0, 0, 0);
    checkOutput("tr_req_valid", 32'(instr_valid), 32'd0);
    checkOutput("tr_req_addr", bus.imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
